// File: rtl/irq_controller.sv
// Interrupt/exception controller: edge-latched pending bits, fixed-priority arbitration, vector redirect.
// Request appears 1 cycle after a source becomes eligible; cause/addr are held until req_ready (no retraction).
module irq_controller #(
  parameter int                N_IRQ      = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter int                VEC_STRIDE = 4,
  parameter int                TMR_W      = 32,
  localparam int               CAUSE_W    = $clog2(N_IRQ + 4)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_global,
  input  logic                 en_nmi,
  input  logic                 en_tmr,
  input  logic                 en_ecall,
  input  logic                 en_ebreak,
  input  logic [N_IRQ-1:0]     irq_en,
  input  logic [N_IRQ-1:0]     irq_i,
  input  logic                 nmi,
  input  logic                 ecall,
  input  logic                 ebreak,
  input  logic [TMR_W-1:0]     tmr_limit,
  input  logic                 req_ready,
  input  logic                 eoi,
  output logic                 req_valid,
  output logic [ADDR_W-1:0]    req_addr,
  output logic [CAUSE_W-1:0]   req_cause,
  output logic                 busy,
  output logic [N_IRQ+3:0]     pending_o
);

  localparam int NSRC      = N_IRQ + 4;
  localparam int STRIDE_SH = $clog2(VEC_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SVC,
    S_NREQ,
    S_NSVC
  } state_t;

  state_t              state_q, state_d;
  logic [NSRC-1:0]     pend_q, pend_d;
  logic [NSRC-1:0]     pend_set, pend_clr, elig;
  logic [N_IRQ-1:0]    irq_prev_q;
  logic                nmi_prev_q;
  logic [TMR_W-1:0]    tcnt_q, tcnt_d;
  logic                tmr_fire;
  logic                nested_q, nested_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d, win_cause;
  logic                win_vld;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                hs;

  function automatic logic [ADDR_W-1:0] vec_addr(input logic [CAUSE_W-1:0] c);
    return VEC_BASE + (ADDR_W'(c) << STRIDE_SH);
  endfunction

  // Free-running period counter; a zero limit parks it without clearing.
  always_comb begin
    tcnt_d   = tcnt_q;
    tmr_fire = 1'b0;
    if (!en_tmr) begin
      tcnt_d = '0;
    end else if (tmr_limit != '0) begin
      if (tcnt_q == tmr_limit - TMR_W'(1)) begin
        tcnt_d   = '0;
        tmr_fire = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TMR_W'(1);
      end
    end
  end

  assign hs       = req_valid & req_ready;
  assign pend_set = {irq_i & ~irq_prev_q, ebreak, ecall, tmr_fire, nmi & ~nmi_prev_q};
  assign pend_clr = hs ? (NSRC'(1) << cause_q) : '0;
  // A new set in the handshake cycle survives the clear.
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  always_comb begin
    elig          = '0;
    elig[0]       = pend_q[0] & en_nmi;
    elig[1]       = pend_q[1] & en_tmr & en_global;
    elig[2]       = pend_q[2] & en_ecall & en_global;
    elig[3]       = pend_q[3] & en_ebreak & en_global;
    elig[NSRC-1:4] = pend_q[NSRC-1:4] & irq_en & {N_IRQ{en_global}};
  end

  always_comb begin
    win_vld   = |elig;
    win_cause = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) win_cause = CAUSE_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    addr_d   = addr_q;
    nested_d = nested_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_REQ;
          cause_d = win_cause;
          addr_d  = vec_addr(win_cause);
        end
      end
      S_REQ: begin
        if (req_ready) state_d = (cause_q == '0) ? S_NSVC : S_SVC;
      end
      S_SVC: begin
        if (eoi) begin
          state_d = S_IDLE;
        end else if (elig[0]) begin
          state_d  = S_NREQ;
          cause_d  = '0;
          addr_d   = VEC_BASE;
          nested_d = 1'b1;
        end
      end
      S_NREQ: begin
        if (req_ready) state_d = S_NSVC;
      end
      S_NSVC: begin
        // Nested NMI returns to the interrupted service, not to IDLE.
        if (eoi) begin
          state_d  = nested_q ? S_SVC : S_IDLE;
          nested_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      irq_prev_q <= '0;
      nmi_prev_q <= 1'b0;
      tcnt_q     <= '0;
      nested_q   <= 1'b0;
      cause_q    <= '0;
      addr_q     <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      irq_prev_q <= irq_i;
      nmi_prev_q <= nmi;
      tcnt_q     <= tcnt_d;
      nested_q   <= nested_d;
      cause_q    <= cause_d;
      addr_q     <= addr_d;
    end
  end

  assign req_valid = (state_q == S_REQ) || (state_q == S_NREQ);
  assign busy      = (state_q != S_IDLE);
  assign req_cause = cause_q;
  assign req_addr  = addr_q;
  assign pending_o = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, hand sequences, random run against a service-stack model.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst, en_global, en_nmi, en_tmr, en_ecall, en_ebreak;
  logic [7:0]  irq_en, irq_i;
  logic        nmi, ecall, ebreak;
  logic [31:0] tmr_limit;
  logic        req_ready, eoi;
  logic        req_valid, busy;
  logic [31:0] req_addr;
  logic [3:0]  req_cause;
  logic [11:0] pending_o;

  int errors = 0;
  int checks = 0;

  irq_controller dut (
    .clk(clk), .rst(rst), .en_global(en_global), .en_nmi(en_nmi), .en_tmr(en_tmr),
    .en_ecall(en_ecall), .en_ebreak(en_ebreak), .irq_en(irq_en), .irq_i(irq_i),
    .nmi(nmi), .ecall(ecall), .ebreak(ebreak), .tmr_limit(tmr_limit),
    .req_ready(req_ready), .eoi(eoi), .req_valid(req_valid), .req_addr(req_addr),
    .req_cause(req_cause), .busy(busy), .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding request plus a stack of causes in service.
  int          m_req = -1;
  int          m_cause = 0;
  int          m_stack[$];
  logic [11:0] m_pend = '0;
  logic [7:0]  m_irq_prev = '0;
  logic        m_nmi_prev = 1'b0;
  logic [31:0] m_cnt = '0;

  task automatic model_step();
    logic [11:0] el, clr, set;
    logic        fire;
    int          w;
    if (rst) begin
      m_req = -1; m_cause = 0; m_stack.delete();
      m_pend = '0; m_irq_prev = '0; m_nmi_prev = 1'b0; m_cnt = '0;
      return;
    end
    fire = 1'b0;
    if (!en_tmr) m_cnt = '0;
    else if (tmr_limit != 0) begin
      if (m_cnt == tmr_limit - 1) begin m_cnt = '0; fire = 1'b1; end
      else m_cnt = m_cnt + 1;
    end
    el[0] = m_pend[0] & en_nmi;
    el[1] = m_pend[1] & en_tmr & en_global;
    el[2] = m_pend[2] & en_ecall & en_global;
    el[3] = m_pend[3] & en_ebreak & en_global;
    for (int k = 0; k < 8; k++) el[4+k] = m_pend[4+k] & irq_en[k] & en_global;
    w = -1;
    for (int i = 0; i < 12; i++) if (el[i] && w < 0) w = i;
    clr = '0;
    if (m_req >= 0) begin
      if (req_ready) begin clr[m_req] = 1'b1; m_stack.push_back(m_req); m_req = -1; end
    end else if (m_stack.size() == 0) begin
      if (w >= 0) begin m_req = w; m_cause = w; end
    end else if (eoi) begin
      void'(m_stack.pop_back());
    end else if (m_stack.size() == 1 && m_stack[0] != 0 && w == 0) begin
      m_req = 0; m_cause = 0;
    end
    set = {irq_i & ~m_irq_prev, ebreak, ecall, fire, nmi & ~m_nmi_prev};
    m_pend = (m_pend & ~clr) | set;
    m_irq_prev = irq_i;
    m_nmi_prev = nmi;
  endtask

  function automatic logic [49:0] model_out();
    logic [31:0] a;
    a = 32'h100 + 32'(m_cause) * 4;
    return {m_req >= 0, 4'(m_cause), a, (m_req >= 0) || (m_stack.size() > 0), m_pend};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       r, eg, en;
    logic [7:0] ie, iq;
    logic       nm, rd, eo;
    logic       ev;
    logic [3:0] ec;
    logic       eb;
    logic [11:0] ep;
  } vec_t;

  function automatic vec_t mk(logic r, logic eg, logic en, logic [7:0] ie, logic [7:0] iq,
                              logic nm, logic rd, logic eo, logic ev, logic [3:0] ec,
                              logic eb, logic [11:0] ep);
    vec_t v;
    v.r = r; v.eg = eg; v.en = en; v.ie = ie; v.iq = iq; v.nm = nm; v.rd = rd; v.eo = eo;
    v.ev = ev; v.ec = ec; v.eb = eb; v.ep = ep;
    return v;
  endfunction

  vec_t tv[$];

  initial begin
    int          t0, t1;
    logic [31:0] ea;
    rst = 1'b1; en_global = 0; en_nmi = 0; en_tmr = 0; en_ecall = 0; en_ebreak = 0;
    irq_en = '0; irq_i = '0; nmi = 0; ecall = 0; ebreak = 0; tmr_limit = '0;
    req_ready = 0; eoi = 0;

    //           r  eg en ie     iq     nm rd eo   ev cause bsy pend
    tv.push_back(mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0,  0, 0, 0, 12'h000));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h00, 0, 0, 0,  0, 0, 0, 12'h000));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 0, 0,  0, 0, 0, 12'h040));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 0, 0,  1, 6, 1, 12'h040));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 0, 0,  1, 6, 1, 12'h040));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 0, 0,  1, 6, 1, 12'h040));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 0, 0,  1, 6, 1, 12'h040));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 1, 0,  0, 6, 1, 12'h000));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h04, 0, 0, 1,  0, 6, 0, 12'h000));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h26, 0, 0, 0,  0, 6, 0, 12'h220));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h26, 0, 0, 0,  1, 5, 1, 12'h220));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h26, 0, 1, 0,  0, 5, 1, 12'h200));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h26, 0, 0, 1,  0, 5, 0, 12'h200));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h26, 0, 0, 0,  1, 9, 1, 12'h200));
    tv.push_back(mk(0, 1, 0, 8'hFF, 8'h26, 0, 1, 0,  0, 9, 1, 12'h000));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 0, 0,  0, 9, 1, 12'h001));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 0, 0,  1, 0, 1, 12'h001));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 0, 1,  1, 0, 1, 12'h001));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 1, 0,  0, 0, 1, 12'h000));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 0, 1,  0, 0, 1, 12'h000));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 0, 0,  0, 0, 1, 12'h000));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h26, 1, 0, 1,  0, 0, 0, 12'h000));
    tv.push_back(mk(0, 0, 1, 8'hFF, 8'h27, 1, 0, 0,  0, 0, 0, 12'h010));
    tv.push_back(mk(0, 0, 1, 8'hFF, 8'h27, 1, 0, 0,  0, 0, 0, 12'h010));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h27, 1, 0, 0,  1, 4, 1, 12'h010));
    tv.push_back(mk(1, 1, 1, 8'hFF, 8'h27, 1, 0, 0,  0, 0, 0, 12'h000));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h00, 0, 0, 0,  0, 0, 0, 12'h000));
    tv.push_back(mk(0, 1, 1, 8'hFF, 8'h00, 0, 0, 1,  0, 0, 0, 12'h000));

    foreach (tv[i]) begin
      rst = tv[i].r; en_global = tv[i].eg; en_nmi = tv[i].en; irq_en = tv[i].ie;
      irq_i = tv[i].iq; nmi = tv[i].nm; req_ready = tv[i].rd; eoi = tv[i].eo;
      tick();
      ea = 32'h100 + 32'(tv[i].ec) * 4;
      check($sformatf("vec%0d", i), {req_valid, req_cause, req_addr, busy, pending_o},
            {tv[i].ev, tv[i].ec, ea, tv[i].eb, tv[i].ep});
    end
    eoi = 0; req_ready = 0;

    // Timer period: fires on the 10th cycle after enable, again 10 cycles later.
    rst = 1; tick(); rst = 0;
    en_global = 1; en_tmr = 1; tmr_limit = 32'd10;
    t0 = -1;
    for (int c = 1; c <= 30 && t0 < 0; c++) begin
      tick();
      if (pending_o[1]) t0 = c;
    end
    check("tmr_first_fire", t0, 10);
    tick();
    check("tmr_req", {req_valid, req_cause, req_addr}, {1'b1, 4'd1, 32'h104});
    req_ready = 1; tick(); req_ready = 0;
    eoi = 1; tick(); eoi = 0;
    check("tmr_idle", {busy, pending_o[1]}, {1'b0, 1'b0});
    t1 = -1;
    for (int c = 14; c <= 40 && t1 < 0; c++) begin
      tick();
      if (pending_o[1]) t1 = c;
    end
    check("tmr_second_fire", t1, 20);
    en_tmr = 0; tmr_limit = '0;

    // Set beats clear; disabling a source does not retract its request.
    rst = 1; tick(); rst = 0;
    en_global = 1; en_ecall = 1;
    ecall = 1; tick(); ecall = 0;
    tick();
    check("ecall_req", {req_valid, req_cause}, {1'b1, 4'd2});
    req_ready = 1; ecall = 1; tick(); ecall = 0; req_ready = 0;
    check("set_beats_clear", {req_valid, busy, pending_o[2]}, {1'b0, 1'b1, 1'b1});
    eoi = 1; tick(); eoi = 0;
    tick();
    check("ecall_rearb", {req_valid, req_cause}, {1'b1, 4'd2});
    en_global = 0; tick();
    check("no_retract", {req_valid, req_cause, req_addr}, {1'b1, 4'd2, 32'h108});
    req_ready = 1; tick(); req_ready = 0;
    check("model_sync", {req_valid, req_cause, req_addr, busy, pending_o}, model_out());

    // Random run against the model.
    rst = 1; tick(); rst = 0;
    tmr_limit = 32'd7; irq_i = '0; nmi = 0;
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      en_global = ($urandom_range(0, 9) != 0);
      en_nmi    = ($urandom_range(0, 5) != 0);
      en_tmr    = ($urandom_range(0, 19) != 0);
      en_ecall  = 1'($urandom);
      en_ebreak = 1'($urandom);
      irq_en    = 8'($urandom);
      irq_i     = irq_i ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) nmi = ~nmi;
      ecall     = ($urandom_range(0, 15) == 0);
      ebreak    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) tmr_limit = 32'($urandom_range(0, 12));
      req_ready = 1'($urandom);
      eoi       = ($urandom_range(0, 4) == 0);
      tick();
      check($sformatf("rand%0d", n), {req_valid, req_cause, req_addr, busy, pending_o}, model_out());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
